// File: rtl/bcd_ascii_streamer.sv
// Streams a captured word of DIGITS BCD digits as ASCII bytes, MSD first, over a valid/ready handshake.
// Define BCD_STREAM_CRLF_EN to append a CR/LF terminator to every frame.
module bcd_ascii_streamer #(
   parameter int unsigned DIGITS       = 4,
   parameter bit          LZ_SUPPRESS  = 1'b0,
   parameter logic [7:0]  INVALID_CHAR = 8'h23
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
`ifdef BCD_STREAM_CRLF_EN
      S_CR,
      S_LF,
`endif
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [4*DIGITS-1:0] digits_q, digits_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                busy_q, busy_d;
   logic [IW-1:0]       load_idx;
   logic [3:0]          cur_nib;

   function automatic logic [7:0] map_digit(input logic [3:0] nib);
      return (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : INVALID_CHAR;
   endfunction

   // Start index: highest non-zero digit when suppressing, so skipped zeros cost no cycles.
   always_comb begin
      load_idx = IW'(DIGITS - 1);
      if (LZ_SUPPRESS) begin
         load_idx = '0;
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] != 4'h0) load_idx = IW'(i);
         end
      end
   end

   always_comb begin
      cur_nib = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (IW'(i) == idx_q) cur_nib = digits_q[4*i +: 4];
      end
   end

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      idx_d    = idx_q;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               digits_d = bcd_in;
               idx_d    = load_idx;
               state_d  = S_SEND;
            end
         end
         S_SEND: begin
            tx_valid = 1'b1;
            tx_data  = map_digit(cur_nib);
            if (tx_ready) begin
               if (idx_q != '0) begin
                  idx_d = idx_q - IW'(1);
               end else begin
`ifdef BCD_STREAM_CRLF_EN
                  state_d = S_CR;
`else
                  state_d = S_DONE;
`endif
               end
            end
         end
`ifdef BCD_STREAM_CRLF_EN
         S_CR: begin
            tx_valid = 1'b1;
            tx_data  = 8'h0D;
            if (tx_ready) state_d = S_LF;
         end
         S_LF: begin
            tx_valid = 1'b1;
            tx_data  = 8'h0A;
            if (tx_ready) state_d = S_DONE;
         end
`endif
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         digits_q <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// Randomized self-checking bench for bcd_ascii_streamer: two instances (LZ off / LZ on) against a queue-based model.
module tb_bcd_ascii_streamer;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] bcd_in = '0;
   logic        tx_ready0 = 1'b1, tx_ready1 = 1'b1;
   logic [7:0]  tx_data0, tx_data1;
   logic        tx_valid0, tx_valid1, busy0, busy1, done0, done1;

   logic        sel = 1'b0;
   logic [7:0]  obs_data;
   logic        obs_valid, obs_busy, obs_done;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   bcd_ascii_streamer #(.DIGITS(4), .LZ_SUPPRESS(1'b0), .INVALID_CHAR(8'h23)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
      .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
      .busy(busy0), .done(done0)
   );

   bcd_ascii_streamer #(.DIGITS(4), .LZ_SUPPRESS(1'b1), .INVALID_CHAR(8'h23)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
      .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
      .busy(busy1), .done(done1)
   );

   assign obs_data  = sel ? tx_data1  : tx_data0;
   assign obs_valid = sel ? tx_valid1 : tx_valid0;
   assign obs_busy  = sel ? busy1     : busy0;
   assign obs_done  = sel ? done1     : done0;

   // Expected byte stream: decimal digits MSD first, optional zero stripping, optional CR/LF.
   function automatic bq_t model(input logic [15:0] w, input bit lz);
      bq_t q;
      int first;
      int nib;
      first = 3;
      if (lz) begin
         first = 0;
         for (int i = 3; i >= 0; i--) begin
            if (((w >> (4*i)) & 16'hF) != 0) begin
               first = i;
               break;
            end
         end
      end
      for (int i = first; i >= 0; i--) begin
         nib = int'((w >> (4*i)) & 16'hF);
         q.push_back(nib <= 9 ? 8'(48 + nib) : 8'h23);
      end
`ifdef BCD_STREAM_CRLF_EN
      q.push_back(8'h0D);
      q.push_back(8'h0A);
`endif
      return q;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      start = 1'b0;
      while ((busy0 !== 1'b0 || busy1 !== 1'b0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
         fails++;
         $display("FAIL wait_idle: busy0=%b busy1=%b required 0 0", busy0, busy1);
      end
   endtask

   // mode 0: always ready; 1: random ready; 2: 3-cycle stall on the 2nd byte.
   task automatic run_frame(input logic [15:0] word, input bit use_lz, input int mode, input string name);
      bq_t  exp_q, got_q;
      int   cycles, done_cnt, done_cyc, last_xfer, stall_left;
      bit   prev_stall, rdy, timed_out;
      logic [7:0] prev_data;
      exp_q = model(word, use_lz);
      wait_idle();
      sel = use_lz;
      tx_ready0 = 1'b1;
      tx_ready1 = 1'b1;
      bcd_in = word;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (obs_valid !== 1'b1 || obs_data !== exp_q[0]) begin
         fails++;
         $display("FAIL %s first_byte: valid=%b data=%h required valid=1 data=%h", name, obs_valid, obs_data, exp_q[0]);
      end
      cycles = 0; done_cnt = 0; done_cyc = -1; last_xfer = -1; stall_left = 3;
      prev_stall = 1'b0; prev_data = '0; timed_out = 1'b1;
      while (cycles < 200) begin
         if (done_cyc >= 0) begin
            start = 1'b0;
            checks++;
            if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
               fails++;
               $display("FAIL %s after_done: busy=%b valid=%b required 0 0", name, obs_busy, obs_valid);
            end
            timed_out = 1'b0;
            break;
         end
         if (prev_stall) begin
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== prev_data) begin
               fails++;
               $display("FAIL %s hold: valid=%b data=%h required valid=1 data=%h", name, obs_valid, obs_data, prev_data);
            end
         end
         if (obs_done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cycles;
         end
         if (obs_valid === 1'b1) begin
            case (mode)
               0: rdy = 1'b1;
               1: rdy = ($urandom_range(0, 2) != 0);
               default: begin
                  rdy = !(got_q.size() == 1 && stall_left > 0);
                  if (!rdy) stall_left--;
               end
            endcase
         end else begin
            rdy = 1'($urandom_range(0, 1));
         end
         if (use_lz) tx_ready1 = rdy; else tx_ready0 = rdy;
         if (obs_valid === 1'b1 && rdy) begin
            got_q.push_back(obs_data);
            last_xfer = cycles;
         end
         prev_stall = (obs_valid === 1'b1) && !rdy;
         prev_data  = obs_data;
         start  = (obs_busy === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
         bcd_in = 16'($urandom);
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      if (timed_out) begin
         checks++;
         fails++;
         $display("FAIL %s timeout: cycles=%0d required done within 200", name, cycles);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL %s length: got %0d bytes required %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL %s byte%0d: got %h required %h", name, i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (done_cnt != 1 || done_cyc != last_xfer + 1) begin
         fails++;
         $display("FAIL %s done: count=%0d at cycle %0d required 1 at cycle %0d", name, done_cnt, done_cyc, last_xfer + 1);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
            fails++;
            $display("FAIL %s extra_frame: valid=%b busy=%b required 0 0", name, obs_valid, obs_busy);
         end
      end
      tx_ready0 = 1'b1;
      tx_ready1 = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx_valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || tx_data0 !== 8'h00 ||
          tx_valid1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || tx_data1 !== 8'h00) begin
         fails++;
         $display("FAIL reset: v=%b%b b=%b%b d=%b%b data=%h/%h required all zero",
                  tx_valid0, tx_valid1, busy0, busy1, done0, done1, tx_data0, tx_data1);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_frame(16'h1234, 1'b0, 0, "basic_1234");
      run_frame(16'h0A09, 1'b0, 0, "invalid_0A09");
   endtask

   task automatic test_backpressure();
      run_frame(16'h1234, 1'b0, 2, "stall_1234");
      run_frame(16'h1234, 1'b1, 2, "stall_lz_1234");
   endtask

   task automatic test_lz();
      run_frame(16'h0050, 1'b1, 0, "lz_0050");
      run_frame(16'h0000, 1'b1, 0, "lz_0000");
      run_frame(16'h00B1, 1'b1, 0, "lz_00B1");
      run_frame(16'h0000, 1'b0, 0, "nolz_0000");
   endtask

   task automatic test_crlf_word();
      run_frame(16'h0007, 1'b0, 0, "word_0007");
   endtask

   task automatic test_reset_abort();
      wait_idle();
      sel = 1'b0;
      tx_ready0 = 1'b1;
      bcd_in = 16'h5678;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (tx_valid0 !== 1'b1 || tx_data0 !== 8'h35) begin
         fails++;
         $display("FAIL abort byte0: valid=%b data=%h required 1 35", tx_valid0, tx_data0);
      end
      @(negedge clk);
      checks++;
      if (tx_valid0 !== 1'b1 || tx_data0 !== 8'h36) begin
         fails++;
         $display("FAIL abort byte1: valid=%b data=%h required 1 36", tx_valid0, tx_data0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (tx_valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || tx_data0 !== 8'h00) begin
         fails++;
         $display("FAIL abort reset: valid=%b busy=%b done=%b data=%h required 0 0 0 00",
                  tx_valid0, busy0, done0, tx_data0);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (tx_valid0 !== 1'b0 || done0 !== 1'b0) begin
            fails++;
            $display("FAIL abort quiet: valid=%b done=%b required 0 0", tx_valid0, done0);
         end
      end
      run_frame(16'h9999, 1'b0, 0, "after_abort_9999");
   endtask

   task automatic test_random();
      logic [15:0] w;
      for (int n = 0; n < 24; n++) begin
         w = 16'($urandom);
         for (int d = 0; d < 4; d++) begin
            if ($urandom_range(0, 2) == 0) w[4*d +: 4] = 4'h0;
         end
         run_frame(w, 1'($urandom_range(0, 1)), 1, "random");
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_lz();
      test_crlf_word();
      test_reset_abort();
      test_random();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
